mem_write_checker: RTL and testbench

Synthesizable self-checking monitor on the MIPS processor's data-memory write port (`writedata`, `dataadr`, `memwrite`, `pc`), the observing end of the `top` outputs that the simulation bench only drives clocks into. It compares every committed store against an ordered expected-write table. It raises sticky pass/fail flags with a cause code and captures the failing store. It also enforces a cycle-count watchdog, so one checker serves both simulation and on-board runs.

---
 rtl/wrchk_pkg.sv | 34 +++
 rtl/wrchk_exp_rom.sv | 11 +
 rtl/mem_write_checker.sv | 141 ++++++++++++++
 tb/tb_mem_write_checker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/wrchk_pkg.sv
// Shared types and the default expected-store table for the data-memory write checker.
package wrchk_pkg;

  localparam int unsigned MaxDepth = 16;

  localparam logic [1:0] CauseNone     = 2'd0;
  localparam logic [1:0] CauseMismatch = 2'd1;
  localparam logic [1:0] CauseTimeout  = 2'd2;
  localparam logic [1:0] CauseHang     = 2'd3;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StPass = 2'd1,
    StFail = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } exp_entry_t;

  // Unused slots read as zero so an out-of-range index can never match by accident of X.
  function automatic exp_entry_t get_exp_entry(input logic [3:0] idx);
    exp_entry_t e;
    e = '{adr: 32'h0, data: 32'h0};
    case (idx)
      4'd0:    e = '{adr: 32'h0000_0054, data: 32'h0000_0007};
      4'd1:    e = '{adr: 32'h0000_0058, data: 32'h0000_000C};
      default: e = '{adr: 32'h0, data: 32'h0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/wrchk_exp_rom.sv
// Combinational lookup of the expected store for the current match index.
module wrchk_exp_rom
  import wrchk_pkg::*;
(
  input  logic [3:0] i_match_idx,
  output exp_entry_t o_exp
);

  assign o_exp = get_exp_entry(i_match_idx);

endmodule

// File: rtl/mem_write_checker.sv
// Monitors data-memory stores against an ordered expected table; sticky pass/fail verdict.
// Optional pc-stall hang detection is built when WRCHK_STALL_DETECT_EN is defined.
module mem_write_checker
  import wrchk_pkg::*;
#(
  parameter int unsigned EXP_DEPTH   = 2,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic [31:0] pc,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  cause,
  output logic [3:0]  match_idx,
  output logic [31:0] fail_adr,
  output logic [31:0] fail_data,
  output logic [31:0] fail_pc,
  output logic [15:0] store_count
);

  localparam logic [4:0]  DepthW   = 5'(EXP_DEPTH);
  localparam logic [31:0] TimeoutW = 32'(TIMEOUT);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cause, w_cause_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [4:0]  w_idx_inc;
  logic [31:0] r_fail_adr, w_fail_adr_nxt;
  logic [31:0] r_fail_data, w_fail_data_nxt;
  logic [31:0] r_fail_pc, w_fail_pc_nxt;
  logic [15:0] r_store_cnt;
  logic [31:0] r_cyc, w_cyc_nxt;
  logic        w_timeout;
  logic        w_stall_hit;
  logic        w_match;
  exp_entry_t  w_exp;

  wrchk_exp_rom u_exp_rom (
    .i_match_idx (r_idx),
    .o_exp       (w_exp)
  );

  assign w_match   = (dataadr == w_exp.adr) && (writedata == w_exp.data);
  assign w_idx_inc = {1'b0, r_idx} + 5'd1;
  assign w_cyc_nxt = (r_cyc == 32'hFFFF_FFFF) ? r_cyc : r_cyc + 32'd1;
  assign w_timeout = (w_cyc_nxt >= TimeoutW);

`ifdef WRCHK_STALL_DETECT_EN
  localparam logic [31:0] StallW = 32'(STALL_LIMIT);

  logic [31:0] r_pc_prev;
  logic [31:0] r_stall, w_stall_nxt;

  assign w_stall_nxt = (pc != r_pc_prev)        ? 32'd0 :
                       (r_stall == 32'hFFFF_FFFF) ? r_stall : r_stall + 32'd1;
  assign w_stall_hit = (w_stall_nxt >= StallW);

  // Previous pc tracks through reset so a pc frozen across reset release still counts.
  always_ff @(posedge clk) begin
    r_pc_prev <= pc;
    if (reset) r_stall <= 32'd0;
    else       r_stall <= w_stall_nxt;
  end
`else
  logic w_unused_stall;
  assign w_unused_stall = (STALL_LIMIT != 0);
  assign w_stall_hit    = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_cause_nxt     = r_cause;
    w_idx_nxt       = r_idx;
    w_fail_adr_nxt  = r_fail_adr;
    w_fail_data_nxt = r_fail_data;
    w_fail_pc_nxt   = r_fail_pc;
    if (r_state == StRun) begin
      if (memwrite && w_match) begin
        w_idx_nxt = w_idx_inc[3:0];
        if (w_idx_inc == DepthW) w_state_nxt = StPass;
      end
      // A final matching store beats every same-edge failure source.
      if (w_state_nxt == StRun) begin
        if (memwrite && !w_match) begin
          w_state_nxt     = StFail;
          w_cause_nxt     = CauseMismatch;
          w_fail_adr_nxt  = dataadr;
          w_fail_data_nxt = writedata;
          w_fail_pc_nxt   = pc;
        end else if (w_timeout) begin
          w_state_nxt   = StFail;
          w_cause_nxt   = CauseTimeout;
          w_fail_pc_nxt = pc;
        end else if (w_stall_hit) begin
          w_state_nxt   = StFail;
          w_cause_nxt   = CauseHang;
          w_fail_pc_nxt = pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StRun;
      r_cause     <= CauseNone;
      r_idx       <= 4'd0;
      r_fail_adr  <= 32'd0;
      r_fail_data <= 32'd0;
      r_fail_pc   <= 32'd0;
      r_cyc       <= 32'd0;
      r_store_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cause     <= w_cause_nxt;
      r_idx       <= w_idx_nxt;
      r_fail_adr  <= w_fail_adr_nxt;
      r_fail_data <= w_fail_data_nxt;
      r_fail_pc   <= w_fail_pc_nxt;
      r_cyc       <= w_cyc_nxt;
      if (memwrite && (r_store_cnt != 16'hFFFF)) r_store_cnt <= r_store_cnt + 16'd1;
    end
  end

  assign done        = (r_state == StPass) || (r_state == StFail);
  assign pass        = (r_state == StPass);
  assign fail        = (r_state == StFail);
  assign cause       = r_cause;
  assign match_idx   = r_idx;
  assign fail_adr    = r_fail_adr;
  assign fail_data   = r_fail_data;
  assign fail_pc     = r_fail_pc;
  assign store_count = r_store_cnt;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: vector table plus multi-cycle corner sequences.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset, memwrite;
  logic [31:0] dataadr, writedata, pc;
  logic        done, pass, fail;
  logic [1:0]  cause;
  logic [3:0]  match_idx;
  logic [31:0] fail_adr, fail_data, fail_pc;
  logic [15:0] store_count;

  int   n_cmp = 0;
  int   n_err = 0;
  logic pc_freeze = 1'b0;

  always #5 clk = ~clk;

  mem_write_checker #(
    .EXP_DEPTH   (2),
    .TIMEOUT     (100),
    .STALL_LIMIT (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .pc          (pc),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .cause       (cause),
    .match_idx   (match_idx),
    .fail_adr    (fail_adr),
    .fail_data   (fail_data),
    .fail_pc     (fail_pc),
    .store_count (store_count)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] adr;
    logic [31:0] data;
    logic [2:0]  dpf;
    logic [1:0]  cause;
    logic [3:0]  idx;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic rst, input logic we, input logic [31:0] adr,
                              input logic [31:0] data, input logic [2:0] dpf,
                              input logic [1:0] c, input logic [3:0] idx,
                              input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.we = we; v.adr = adr; v.data = data;
    v.dpf = dpf; v.cause = c; v.idx = idx; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!pc_freeze) pc = pc + 32'd4;
  endtask

  task automatic do_reset();
    reset = 1'b1; memwrite = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] data);
    memwrite = 1'b1; dataadr = adr; writedata = data;
    tick();
    memwrite = 1'b0;
  endtask

  logic [31:0] exp_pc;

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; pc = 32'h100;

    //              rst   we    adr     data    dpf     cause idx cnt
    vecs[0]  = mk(1'b1, 1'b0, 32'h00, 32'h0, 3'b000, 2'd0, 4'd0, 16'd0);
    vecs[1]  = mk(1'b0, 1'b0, 32'h00, 32'h0, 3'b000, 2'd0, 4'd0, 16'd0);
    vecs[2]  = mk(1'b0, 1'b1, 32'h54, 32'h7, 3'b000, 2'd0, 4'd1, 16'd1);
    vecs[3]  = mk(1'b0, 1'b1, 32'h58, 32'hC, 3'b110, 2'd0, 4'd2, 16'd2);
    vecs[4]  = mk(1'b0, 1'b1, 32'h54, 32'h8, 3'b110, 2'd0, 4'd2, 16'd3);
    vecs[5]  = mk(1'b1, 1'b0, 32'h00, 32'h0, 3'b000, 2'd0, 4'd0, 16'd0);
    vecs[6]  = mk(1'b0, 1'b1, 32'h54, 32'h7, 3'b000, 2'd0, 4'd1, 16'd1);
    vecs[7]  = mk(1'b0, 1'b1, 32'h58, 32'hD, 3'b101, 2'd1, 4'd1, 16'd2);
    vecs[8]  = mk(1'b0, 1'b1, 32'h58, 32'hC, 3'b101, 2'd1, 4'd1, 16'd3);
    vecs[9]  = mk(1'b1, 1'b1, 32'h58, 32'hC, 3'b000, 2'd0, 4'd0, 16'd0);
    vecs[10] = mk(1'b0, 1'b1, 32'h58, 32'hC, 3'b101, 2'd1, 4'd0, 16'd1);
    vecs[11] = mk(1'b1, 1'b0, 32'h00, 32'h0, 3'b000, 2'd0, 4'd0, 16'd0);
    vecs[12] = mk(1'b0, 1'b1, 32'h54, 32'h7, 3'b000, 2'd0, 4'd1, 16'd1);
    vecs[13] = mk(1'b0, 1'b1, 32'h54, 32'h7, 3'b101, 2'd1, 4'd1, 16'd2);

    for (int i = 0; i < 14; i++) begin
      reset = vecs[i].rst; memwrite = vecs[i].we;
      dataadr = vecs[i].adr; writedata = vecs[i].data;
      tick();
      reset = 1'b0; memwrite = 1'b0;
      chk($sformatf("vec%0d {done,pass,fail,cause,idx,cnt}", i),
          32'({done, pass, fail, cause, match_idx, store_count}),
          32'({vecs[i].dpf, vecs[i].cause, vecs[i].idx, vecs[i].cnt}));
    end

    // Mismatch capture, then captures frozen by later stores.
    do_reset();
    pc = 32'h3C;
    store(32'h54, 32'h8);
    chk("mm_fail", 32'(fail), 32'd1);
    chk("mm_cause", 32'(cause), 32'd1);
    chk("mm_adr", fail_adr, 32'h54);
    chk("mm_data", fail_data, 32'h8);
    chk("mm_pc", fail_pc, 32'h3C);
    store(32'h58, 32'hC);
    chk("mm_hold_adr", fail_adr, 32'h54);
    chk("mm_hold_data", fail_data, 32'h8);
    chk("mm_hold_pc", fail_pc, 32'h3C);
    chk("mm_hold_cnt", 32'(store_count), 32'd2);

    // Watchdog fires exactly 100 cycles after reset release.
    do_reset();
    for (int i = 0; i < 99; i++) tick();
    chk("to_pre_fail", 32'(fail), 32'd0);
    exp_pc = pc;
    tick();
    chk("to_fail", 32'(fail), 32'd1);
    chk("to_done", 32'(done), 32'd1);
    chk("to_cause", 32'(cause), 32'd2);
    chk("to_pc", fail_pc, exp_pc);
    chk("to_adr_data", fail_adr | fail_data, 32'd0);

    // Reset after FAIL, then the correct sequence passes with a fresh count.
    do_reset();
    chk("rst_clear_fail", 32'(fail), 32'd0);
    store(32'h54, 32'h7);
    store(32'h58, 32'hC);
    chk("rerun_pass", 32'(pass), 32'd1);
    chk("rerun_cnt", 32'(store_count), 32'd2);

    // Final match on the watchdog expiry edge: pass wins.
    do_reset();
    for (int i = 0; i < 98; i++) tick();
    store(32'h54, 32'h7);
    store(32'h58, 32'hC);
    chk("race_pass", 32'(pass), 32'd1);
    chk("race_fail", 32'(fail), 32'd0);
    chk("race_cause", 32'(cause), 32'd0);

    // memwrite held high counts every cycle.
    do_reset();
    memwrite = 1'b1; dataadr = 32'h10; writedata = 32'h1;
    tick(); tick(); tick();
    memwrite = 1'b0;
    chk("held_cnt", 32'(store_count), 32'd3);

`ifdef WRCHK_STALL_DETECT_EN
    pc_freeze = 1'b1;
    pc = 32'h20;
    do_reset();
    for (int i = 0; i < 63; i++) tick();
    chk("hang_pre_fail", 32'(fail), 32'd0);
    tick();
    chk("hang_fail", 32'(fail), 32'd1);
    chk("hang_cause", 32'(cause), 32'd3);
    chk("hang_pc", fail_pc, 32'h20);
    pc_freeze = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
